// File: rtl/configurations_pkg.sv
// Shared configuration for the vector core's data-memory responder: defaults
// and the read-pipeline stage record.
package configurations_pkg;

  localparam int READ_LATENCY_DEFAULT    = 2;
  localparam int MEM_DEPTH_WORDS_DEFAULT = 4096;
  localparam int DATA_WIDTH_DEFAULT      = 32;

  // Stage payload is sized for the widest supported word; narrower words are zero-extended.
  localparam int RD_STAGE_DATA_W = 64;

  typedef struct packed {
    logic                       valid;
    logic                       err;
    logic [RD_STAGE_DATA_W-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/rd_delay_pipe.sv
// Fixed-length shift register carrying read responses; only the valid bits
// are reset so that a reset drops every in-flight read.
module rd_delay_pipe
  import configurations_pkg::*;
#(
  parameter int LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  rd_stage_t stage_i,
  output rd_stage_t stage_o
);

  logic [LATENCY-1:0]         valid_q;
  logic [LATENCY-1:0]         err_q;
  logic [RD_STAGE_DATA_W-1:0] data_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= stage_i.valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    err_q[0]  <= stage_i.err;
    data_q[0] <= stage_i.data;
    for (int i = 1; i < LATENCY; i++) begin
      err_q[i]  <= err_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  always_comb begin
    stage_o       = '0;
    stage_o.valid = valid_q[LATENCY-1];
    stage_o.err   = err_q[LATENCY-1];
    stage_o.data  = data_q[LATENCY-1];
  end

endmodule

// File: rtl/v_data_mem_responder.sv
// Data-memory responder for the vector core: word array, fixed-latency read
// return, alignment/range checking and saturating access counters.
module v_data_mem_responder
  import configurations_pkg::*;
#(
  parameter int                    DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    MEM_DEPTH_WORDS = MEM_DEPTH_WORDS_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    READ_LATENCY    = READ_LATENCY_DEFAULT,
  parameter int                    CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_we_i,
  input  logic                  mem_re_i,
  input  logic [ADDR_WIDTH-1:0] data_mem_addr_i,
  input  logic [DATA_WIDTH-1:0] data_to_mem_i,
  output logic [DATA_WIDTH-1:0] data_from_mem_o,
  output logic                  rdata_valid_o,
  output logic                  addr_err_o,
  output logic [CNT_WIDTH-1:0]  rd_count_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o,
  input  logic                  clear_counts_i
);

  localparam int                  IDX_W     = $clog2(MEM_DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * longint'(MEM_DEPTH_WORDS));

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH > RD_STAGE_DATA_W) begin : g_bad_width
    $error("DATA_WIDTH exceeds read stage payload width");
  end

  // Handshake: mem_we_i/mem_re_i are single-cycle requests accepted
  // unconditionally every cycle; a read answers with one rdata_valid_o pulse
  // exactly READ_LATENCY cycles later and there is no backpressure.
  logic [ADDR_WIDTH:0]   off_ext;
  logic                  addr_legal;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];

  // The borrow out of the subtraction flags addresses below BASE_ADDR.
  assign off_ext    = {1'b0, data_mem_addr_i} - {1'b0, BASE_ADDR};
  assign addr_legal = (data_mem_addr_i[1:0] == 2'b00) && !off_ext[ADDR_WIDTH] &&
                      (off_ext < MEM_BYTES);
  assign word_idx   = off_ext[IDX_W+1:2];
  assign rd_word    = mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (mem_we_i && addr_legal) begin
      mem_q[word_idx] <= data_to_mem_i;
    end
  end

  rd_stage_t rd_in;
  rd_stage_t rd_out;

  always_comb begin
    rd_in       = '0;
    rd_in.valid = mem_re_i;
    rd_in.err   = !addr_legal;
    rd_in.data  = addr_legal ? RD_STAGE_DATA_W'(rd_word) : '0;
  end

  rd_delay_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_delay_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .stage_i (rd_in),
    .stage_o (rd_out)
  );

  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_out.data;

  logic [DATA_WIDTH-1:0] hold_q;
  logic                  wr_err_q;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;

  // Clear beats increment; both counters stick at all-ones.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (clear_counts_i) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (mem_re_i && addr_legal && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
      if (mem_we_i && addr_legal && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      wr_err_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_out.valid) hold_q <= rd_out.data[DATA_WIDTH-1:0];
      wr_err_q <= mem_we_i && !addr_legal;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read and write errors landing in the same cycle share one pulse.
  assign data_from_mem_o = rd_out.valid ? rd_out.data[DATA_WIDTH-1:0] : hold_q;
  assign rdata_valid_o   = rd_out.valid;
  assign addr_err_o      = (rd_out.valid && rd_out.err) || wr_err_q;
  assign rd_count_o      = rd_cnt_q;
  assign wr_count_o      = wr_cnt_q;

endmodule

// File: tb/tb_v_data_mem_responder.sv
// Directed bench for v_data_mem_responder with a queue-based response scoreboard.
`timescale 1ns/1ps
module tb_v_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        clr = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        aerr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] exp_q[$];
  int          due_q[$];
  int          werr_q[$];

  v_data_mem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .mem_we_i        (mem_we),
    .mem_re_i        (mem_re),
    .data_mem_addr_i (addr),
    .data_to_mem_i   (wdata),
    .data_from_mem_o (rdata),
    .rdata_valid_o   (rvalid),
    .addr_err_o      (aerr),
    .rd_count_o      (rd_cnt),
    .wr_count_o      (wr_cnt),
    .clear_counts_i  (clr)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_rerr, input logic exp_werr, input logic c);
    @(posedge clk);
    #1;
    mem_we = we;
    mem_re = re;
    addr   = a;
    wdata  = wd;
    clr    = c;
    if (re) begin
      exp_q.push_back({exp_rerr, exp_rd});
      due_q.push_back(cyc + LAT);
    end
    if (we && exp_werr) werr_q.push_back(cyc + 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr_bad(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d);
    drive(1'b0, 1'b1, a, 32'h0, exp_d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_bad(input logic [31:0] a);
    drive(1'b0, 1'b1, a, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    int          d;
    logic        werr_due;
    logic        exp_err;
    if (reset) begin
      exp_err  = 1'b0;
      werr_due = (werr_q.size() > 0) && (werr_q[0] == cyc);
      if (werr_due) void'(werr_q.pop_front());
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected rdata_valid", 64'(rvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("rdata value", 64'(rdata), 64'(e[31:0]));
          check("rdata latency", 64'(cyc), 64'(d));
          exp_err = e[32];
        end
      end else if (due_q.size() > 0 && due_q[0] < cyc) begin
        check("missing rdata_valid", 64'(rvalid), 64'd1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (aerr || exp_err || werr_due) check("addr_err", 64'(aerr), 64'(exp_err | werr_due));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset data", 64'(rdata), 64'd0);
    check("reset valid", 64'(rvalid), 64'd0);
    check("reset err", 64'(aerr), 64'd0);
    check("reset rd_count", 64'(rd_cnt), 64'd0);
    check("reset wr_count", 64'(wr_cnt), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // write then read back
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    idle_n(4);
    check("t1 wr_count", 64'(wr_cnt), 64'd1);
    check("t1 rd_count", 64'(rd_cnt), 64'd1);

    // back-to-back reads
    for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'(i * 3));
    for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'(i * 3));
    idle_n(4);

    // same-cycle write and read
    wr(32'h20, 32'h1);
    drive(1'b1, 1'b1, 32'h20, 32'h2, 32'h1, 1'b0, 1'b0, 1'b0);
    rd(32'h20, 32'h2);
    idle_n(4);
    check("t3 hold data", 64'(rdata), 64'h2);
    check("t3 wr_count", 64'(wr_cnt), 64'd11);
    check("t3 rd_count", 64'(rd_cnt), 64'd11);

    // address errors, including a merged read/write error pulse
    rd_bad(32'h13);
    rd_bad(32'h4000);
    idle_n(3);
    wr_bad(32'h4000, 32'hBAD);
    idle_n(1);
    rd(32'h0, 32'h0);
    rd_bad(32'h3);
    wr_bad(32'h5, 32'h1);
    idle_n(4);
    check("t4 rd_count", 64'(rd_cnt), 64'd12);
    check("t4 wr_count", 64'(wr_cnt), 64'd11);

    // reset with reads in flight
    rd(32'h4, 32'h3);
    rd(32'h8, 32'h6);
    #3;
    reset  = 1'b0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    exp_q.delete();
    due_q.delete();
    werr_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    check("t5 data", 64'(rdata), 64'd0);
    check("t5 valid", 64'(rvalid), 64'd0);
    check("t5 rd_count", 64'(rd_cnt), 64'd0);
    check("t5 wr_count", 64'(wr_cnt), 64'd0);
    idle_n(5);
    rd(32'h20, 32'h2);

    // counter saturation and clear priority
    for (int i = 0; i < 16'hFFFD; i++) rd(32'h0, 32'h0);
    wr(32'h24, 32'h5);
    idle_n(1);
    check("t6 rd_count 0xFFFE", 64'(rd_cnt), 64'hFFFE);
    rd(32'h0, 32'h0);
    idle_n(1);
    check("t6 rd_count 0xFFFF", 64'(rd_cnt), 64'hFFFF);
    rd(32'h0, 32'h0);
    idle_n(1);
    check("t6 rd_count held", 64'(rd_cnt), 64'hFFFF);
    check("t6 wr_count", 64'(wr_cnt), 64'd1);
    drive(1'b0, 1'b1, 32'h24, 32'h0, 32'h5, 1'b0, 1'b0, 1'b1);
    idle_n(1);
    check("t6 rd_count cleared", 64'(rd_cnt), 64'd0);
    check("t6 wr_count cleared", 64'(wr_cnt), 64'd0);

    idle_n(6);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_data_mem_responder.md
Name: v_data_mem_responder

Overview:
Memory-side responder for the vector core's data memory port. It receives the core's mem_we/mem_re/address/write-data strobes and returns read data after a fixed, parameterised latency. It contains the word array, a read-delay pipeline, alignment and range checking, and saturating access counters for the verification environment. It sits between the vector core and the bench. It is synthesisable and also serves as the reference memory model.

Parameters:
DATA_WIDTH, 32, width of data words
ADDR_WIDTH, 32, width of the byte address
MEM_DEPTH_WORDS, 4096, number of words stored (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, cycles from accepted read to data valid; legal range 1..4, elaboration error otherwise
CNT_WIDTH, 16, width of the access counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
mem_we_i  in  1  write strobe from the core
mem_re_i  in  1  read strobe from the core
data_mem_addr_i  in  ADDR_WIDTH  byte address
data_to_mem_i  in  DATA_WIDTH  write data from the core
data_from_mem_o  out  DATA_WIDTH  read data returned to the core
rdata_valid_o  out  1  one-cycle pulse marking a returned read
addr_err_o  out  1  one-cycle pulse, READ_LATENCY-aligned for reads and next-cycle for writes
rd_count_o  out  CNT_WIDTH  accepted valid reads
wr_count_o  out  CNT_WIDTH  accepted valid writes
clear_counts_i  in  1  synchronous clear of both counters

Behaviour:
- Reset (reset=0, asynchronous):
  - data_from_mem_o=0, rdata_valid_o=0, addr_err_o=0, counters=0.
  - All read-pipeline valid bits are cleared.
  - Memory contents are not reset.
- Reset asserted mid-operation: in-flight reads are discarded. No rdata_valid_o pulse appears for them after reset releases.
- Address decode:
  - off = addr - BASE_ADDR; word index = off[..:2].
  - An access is legal when addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH_WORDS.
- Write, cycle N with mem_we_i=1:
  - Legal: the array is updated at edge N and wr_count increments.
  - Illegal: the array is untouched, the counter is unchanged, and addr_err_o pulses at N+1.
- Read, cycle N with mem_re_i=1:
  - The array is sampled at edge N (read-before-write).
  - The data travels through READ_LATENCY pipeline stages.
  - At cycle N+READ_LATENCY: data_from_mem_o = sampled word and rdata_valid_o=1 for exactly one cycle.
  - Illegal read: returns 0, rdata_valid_o=1, and addr_err_o=1 in the same cycle as the data. rd_count is not incremented.
- Throughput: one read per cycle. Back-to-back reads produce consecutive valid pulses in order.
- data_from_mem_o holds its last value when rdata_valid_o=0.
- Simultaneous we and re in one cycle: both are performed.
  - Same address: the read returns the old data and the write lands.
  - A write to an address with a read in flight does not alter the in-flight data.
- addr_err collision: a write error (N+1) and a read error (N+READ_LATENCY) due in the same cycle merge into a single pulse.
- Counters:
  - Saturate at all-ones; no wrap.
  - clear_counts_i has priority over an increment in the same cycle.
- There is no backpressure. The core must tolerate the fixed latency.

Decomposition:
- Add to configurations_pkg:
  - READ_LATENCY_DEFAULT.
  - A typedef for the read-pipeline stage struct {valid, err, data}.
  - The MEM_DEPTH_WORDS default.
- Sub-module rd_delay_pipe: a shift register of READ_LATENCY stages carrying the stage struct. It uses an async active-low reset on the valid bits only.
- Address check and counters stay in the top module.

Test Plan:
1. Write 0xDEADBEEF @0x10 at N, read 0x10 at N+1 (READ_LATENCY=2) -> data_from_mem_o=0xDEADBEEF with rdata_valid_o=1 only at N+3. wr_count=1, rd_count=1.
2. Eight back-to-back reads of 0x0..0x1C preloaded with i*3 -> eight consecutive valid cycles returning 0,3,...,21 in order.
3. Same-cycle we+re @0x20 (old 0x1, new 0x2) -> read returns 0x1. A following read returns 0x2.
4. Read @0x13 (misaligned) and read @BASE+0x4000 with depth 4096 -> data 0, rdata_valid_o=1, addr_err_o=1. rd_count unchanged.
5. Issue 2 reads, then assert reset for 1 cycle before data returns -> no rdata_valid_o after release. Outputs and counters are 0.
6. Preset rd_count to 0xFFFE via 3 reads past 0xFFFD -> holds 0xFFFF. Assert clear_counts_i concurrently with a read -> counter is 0.
